// File: rtl/iterative_alu.sv
// Single-issue ALU: 1-cycle logic/compare/shift ops, bit-serial multiply, and bit-serial divide when ITERATIVE_ALU_DIV_EN is defined.
// Latency 1 cycle, or DATA_WIDTH+1 for multiply/divide; op_ready stays low until the held result is taken via result_ready.
module iterative_alu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [5:0]            ALU_operation,
  input  logic [DATA_WIDTH-1:0] operand_A,
  input  logic [DATA_WIDTH-1:0] operand_B,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [DATA_WIDTH-1:0] ALU_result,
  output logic                  busy
);
  localparam int W   = DATA_WIDTH;
  localparam int SHW = $clog2(W) + 1;
  localparam int CW  = $clog2(W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
`ifdef ITERATIVE_ALU_DIV_EN
    DIV  = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    result_q, result_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [W-1:0]    mcand_q, mcand_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      sub_q, sub_d;
  logic            neg_q, neg_d;

  logic            accept;
  logic [SHW-1:0]  shamt;
  logic [4:0]      shamt_w;
  logic signed [31:0] w32;
  logic [W-1:0]    alu_res;
  logic            sa_eff, sb_eff, neg_sel;
  logic [W-1:0]    mag_a, mag_b;
  logic [W:0]      mul_sum;
  logic [2*W-1:0]  mul_next, prod;
`ifdef ITERATIVE_ALU_DIV_EN
  logic            div_ovf, div_special;
  logic [W:0]      div_trial;
  logic [2*W-1:0]  div_next;
  logic [W-1:0]    div_pick, div_res;
`endif

  assign accept       = op_valid & op_ready;
  assign result_valid = (state_q == DONE);
  assign op_ready     = (state_q == IDLE) & ~result_valid;
  assign busy         = (state_q != IDLE) & (state_q != DONE);
  assign ALU_result   = result_q;
  assign shamt        = operand_B[SHW-1:0];
  assign shamt_w      = operand_B[4:0];

  // Bit 3 of the code separates divide (24-27) from multiply (20-23) operand signedness.
  assign sa_eff  = ALU_operation[3] ? (~ALU_operation[0] & operand_A[W-1])
                                    : ((ALU_operation[1:0] != 2'b11) & operand_A[W-1]);
  assign sb_eff  = ALU_operation[3] ? (~ALU_operation[0] & operand_B[W-1])
                                    : (~ALU_operation[1] & operand_B[W-1]);
  assign neg_sel = (ALU_operation[3] & ALU_operation[1]) ? sa_eff : (sa_eff ^ sb_eff);
  assign mag_a   = sa_eff ? -operand_A : operand_A;
  assign mag_b   = sb_eff ? -operand_B : operand_B;

`ifdef ITERATIVE_ALU_DIV_EN
  assign div_ovf     = ~ALU_operation[0] & (operand_A == {1'b1, {(W-1){1'b0}}}) & (&operand_B);
  assign div_special = (operand_B == '0) | div_ovf;
`endif

  always_comb begin
    alu_res = '0;
    w32     = '0;
    case (ALU_operation)
      6'd0:  alu_res = operand_A + operand_B;
      6'd1:  alu_res = operand_A;
      6'd2:  alu_res[0] = (operand_A == operand_B);
      6'd3:  alu_res[0] = (operand_A != operand_B);
      6'd4:  alu_res[0] = ($signed(operand_A) <  $signed(operand_B));
      6'd5:  alu_res[0] = ($signed(operand_A) >= $signed(operand_B));
      6'd6:  alu_res[0] = (operand_A <  operand_B);
      6'd7:  alu_res[0] = (operand_A >= operand_B);
      6'd8:  alu_res = operand_A ^ operand_B;
      6'd9:  alu_res = operand_A | operand_B;
      6'd10: alu_res = operand_A & operand_B;
      6'd11: alu_res = operand_A << shamt;
      6'd12: alu_res = operand_A >> shamt;
      6'd13: alu_res = $signed(operand_A) >>> shamt;
      6'd14: alu_res = operand_A - operand_B;
      6'd15: begin w32 = operand_A[31:0] + operand_B[31:0];   alu_res = W'(w32); end
      6'd16: begin w32 = operand_A[31:0] << shamt_w;          alu_res = W'(w32); end
      6'd17: begin w32 = operand_A[31:0] >> shamt_w;          alu_res = W'(w32); end
      6'd18: begin w32 = $signed(operand_A[31:0]) >>> shamt_w; alu_res = W'(w32); end
      6'd19: begin w32 = operand_A[31:0] - operand_B[31:0];   alu_res = W'(w32); end
`ifdef ITERATIVE_ALU_DIV_EN
      6'd24, 6'd25, 6'd26, 6'd27: begin
        if (operand_B == '0) alu_res = ALU_operation[1] ? operand_A : '1;
        else if (div_ovf)    alu_res = ALU_operation[1] ? '0 : operand_A;
      end
`endif
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    sub_d    = sub_q;
    neg_d    = neg_q;

    // acc holds {partial product, remaining multiplier bits}.
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    mul_next = {mul_sum, acc_q[W-1:1]};
    prod     = neg_q ? -mul_next : mul_next;
`ifdef ITERATIVE_ALU_DIV_EN
    // acc holds {partial remainder, remaining dividend / growing quotient}.
    div_trial = acc_q[2*W-1:W-1] - {1'b0, mcand_q};
    div_next  = div_trial[W] ? {acc_q[2*W-2:0], 1'b0}
                             : {div_trial[W-1:0], acc_q[W-2:0], 1'b1};
    div_pick  = sub_q[1] ? div_next[2*W-1:W] : div_next[W-1:0];
    div_res   = neg_q ? -div_pick : div_pick;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = DONE;
          result_d = alu_res;
          cnt_d    = '0;
          sub_d    = ALU_operation[1:0];
          neg_d    = neg_sel;
          if (ALU_operation inside {[6'd20:6'd23]}) begin
            state_d = MUL;
            acc_d   = {{W{1'b0}}, mag_b};
            mcand_d = mag_a;
          end
`ifdef ITERATIVE_ALU_DIV_EN
          else if ((ALU_operation inside {[6'd24:6'd27]}) && !div_special) begin
            state_d = DIV;
            acc_d   = {{W{1'b0}}, mag_a};
            mcand_d = mag_b;
          end
`endif
        end
      end
      MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W-1)) begin
          state_d  = DONE;
          result_d = (sub_q == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
        end
      end
`ifdef ITERATIVE_ALU_DIV_EN
      DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W-1)) begin
          state_d  = DONE;
          result_d = div_res;
        end
      end
`endif
      DONE: begin
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      sub_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
      sub_q    <= sub_d;
      neg_q    <= neg_d;
    end
  end
endmodule

// File: tb/tb_iterative_alu.sv
// Scoreboard bench for iterative_alu (DATA_WIDTH=32): driver pushes model results, monitor pops on each new result.
module tb_iterative_alu;
  localparam int DW = 32;

  logic          clock;
  logic          reset;
  logic          op_valid;
  logic          op_ready;
  logic [5:0]    ALU_operation;
  logic [DW-1:0] operand_A;
  logic [DW-1:0] operand_B;
  logic          result_valid;
  logic          result_ready;
  logic [DW-1:0] ALU_result;
  logic          busy;

  iterative_alu #(.DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .ALU_operation(ALU_operation), .operand_A(operand_A), .operand_B(operand_B),
    .result_valid(result_valid), .result_ready(result_ready),
    .ALU_result(ALU_result), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          stall;
    int          acc_cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: condition not met within its cycle budget", name);
  endtask

  // Reference: RISC-V style results from 64-bit arithmetic; lat is the expected accept-to-valid distance.
  function automatic logic [31:0] model(input logic [5:0] op, input logic [31:0] a,
                                        input logic [31:0] b, output int lat);
    longint      sa, sb_, q;
    logic [63:0] ua, ub, p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    lat = 1;
    r = '0;
    case (op)
      6'd0:  r = a + b;
      6'd1:  r = a;
      6'd2:  r = {31'b0, a == b};
      6'd3:  r = {31'b0, a != b};
      6'd4:  r = {31'b0, sa < sb_};
      6'd5:  r = {31'b0, sa >= sb_};
      6'd6:  r = {31'b0, a < b};
      6'd7:  r = {31'b0, a >= b};
      6'd8:  r = a ^ b;
      6'd9:  r = a | b;
      6'd10: r = a & b;
      6'd11: begin p = ua << b[5:0]; r = p[31:0]; end
      6'd12: begin p = ua >> b[5:0]; r = p[31:0]; end
      6'd13: begin q = sa >>> b[5:0]; r = q[31:0]; end
      6'd14: r = a - b;
      6'd15: r = a + b;
      6'd16: r = a << b[4:0];
      6'd17: r = a >> b[4:0];
      6'd18: begin q = sa >>> b[4:0]; r = q[31:0]; end
      6'd19: r = a - b;
      6'd20: begin q = sa * sb_; r = q[31:0]; lat = 33; end
      6'd21: begin q = (sa * sb_) >>> 32; r = q[31:0]; lat = 33; end
      6'd22: begin q = (sa * longint'(ub)) >>> 32; r = q[31:0]; lat = 33; end
      6'd23: begin p = ua * ub; r = p[63:32]; lat = 33; end
`ifdef ITERATIVE_ALU_DIV_EN
      6'd24, 6'd26: begin
        if (b == 0)                                  r = (op == 6'd24) ? 32'hFFFF_FFFF : a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = (op == 6'd24) ? a : 32'h0;
        else begin
          q = (op == 6'd24) ? (sa / sb_) : (sa % sb_);
          r = q[31:0];
          lat = 33;
        end
      end
      6'd25, 6'd27: begin
        if (b == 0) r = (op == 6'd25) ? 32'hFFFF_FFFF : a;
        else begin
          r = (op == 6'd25) ? (a / b) : (a % b);
          lat = 33;
        end
      end
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int stall, input bit push, input string name);
    exp_t e;
    int   lat;
    int   guard;
    @(negedge clock);
    ALU_operation = op;
    operand_A     = a;
    operand_B     = b;
    op_valid      = 1'b1;
    guard = 0;
    while (!op_ready && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (!op_ready) begin
      fail_now({"accept_", name});
      op_valid = 1'b0;
      return;
    end
    e.res     = model(op, a, b, lat);
    e.lat     = lat;
    e.stall   = stall;
    e.acc_cyc = cyc;
    e.name    = name;
    if (push) sb.push_back(e);
    @(posedge clock);
    #1 op_valid = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 70));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: checks each new result once, then holds result_ready low for the requested stall.
  initial begin : monitor
    exp_t e;
    bit   seen;
    bit   rdy_given;
    int   stall_left;
    seen = 0;
    rdy_given = 0;
    stall_left = 0;
    result_ready = 1'b1;
    forever begin
      @(negedge clock);
      if (result_valid) begin
        if (!seen) begin
          seen = 1;
          rdy_given = 0;
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: got 0x%0h with nothing outstanding", ALU_result);
            stall_left = 0;
          end else begin
            e = sb.pop_front();
            check(e.name, ALU_result, e.res);
            check({e.name, "_latency"}, cyc - e.acc_cyc, e.lat);
            stall_left = e.stall;
          end
        end else if (sb.size() >= 0 && !rdy_given) begin
          check({e.name, "_hold"}, ALU_result, e.res);
        end
        if (stall_left > 0) begin
          stall_left--;
          result_ready = 1'b0;
        end else begin
          result_ready = 1'b1;
          rdy_given = 1;
        end
      end else begin
        if (seen && !rdy_given) begin
          n_checks++;
          n_fail++;
          $display("FAIL valid_dropped: result_valid 0 before result_ready, required 1");
        end
        seen = 0;
        result_ready = 1'b1;
      end
    end
  end

  initial begin : stimulus
    int guard;
    logic [5:0] op;
    reset = 1'b0;
    op_valid = 1'b0;
    ALU_operation = '0;
    operand_A = '0;
    operand_B = '0;
    repeat (3) @(negedge clock);
    check("reset_result_valid", result_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_ALU_result", ALU_result, 32'h0);
    reset = 1'b1;
    @(negedge clock);
    check("op_ready_after_reset", op_ready, 1'b1);

    issue(6'd0,  32'd5,         32'd7,         0, 1, "add_5_7");
    issue(6'd23, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, "mulhu_ones");
    issue(6'd20, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, "mul_ones");
    issue(6'd21, 32'hFFFF_FFFD, 32'd5,         0, 1, "mulh_neg3_5");
    issue(6'd22, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, "mulhsu_neg1_max");
    issue(6'd24, 32'hFFFF_FFF9, 32'd2,         0, 1, "div_neg7_2");
    issue(6'd26, 32'hFFFF_FFF9, 32'd2,         0, 1, "rem_neg7_2");
    issue(6'd25, 32'd7,         32'd0,         0, 1, "divu_by_zero");
    issue(6'd27, 32'd7,         32'd0,         0, 1, "remu_by_zero");
    issue(6'd24, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, "div_overflow");
    issue(6'd26, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, "rem_overflow");
    issue(6'd11, 32'h0000_0001, 32'd40,        0, 1, "sll_by_40");
    issue(6'd13, 32'h8000_0000, 32'd33,        0, 1, "sra_by_33");
    issue(6'd18, 32'h8000_0000, 32'd36,        0, 1, "sraw_by_4");
    issue(6'd45, 32'h1234_5678, 32'h1,         0, 1, "undefined_code");

    // Held result: new requests during the stall must be refused.
    issue(6'd0, 32'd1, 32'd2, 5, 1, "add_stalled");
    guard = 0;
    while (!result_valid && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    if (!result_valid) fail_now("stall_result_appears");
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clock);
      ALU_operation = 6'd1;
      operand_A = 32'hDEAD_BEEF;
      op_valid = 1'b1;
      check("op_ready_while_held", op_ready, 1'b0);
    end
    op_valid = 1'b0;

    // Reset mid-multiply abandons the operation.
    issue(6'd20, 32'h1234_5678, 32'h9ABC_DEF1, 0, 0, "mul_abandoned");
    repeat (9) @(posedge clock);
    #1 check("busy_during_mul", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("async_reset_result_valid", result_valid, 1'b0);
    check("async_reset_busy", busy, 1'b0);
    check("async_reset_ALU_result", ALU_result, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("op_ready_after_release", op_ready, 1'b1);
    issue(6'd0, 32'd1, 32'd1, 0, 1, "add_after_reset");

    for (int n = 0; n < 120; n++) begin
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(28, 63)) : 6'($urandom_range(0, 27));
      issue(op, pick(), pick(), $urandom_range(0, 2), 1, $sformatf("rand%0d_op%0d", n, op));
    end

    guard = 0;
    while (sb.size() != 0 && guard < 2000) begin
      @(negedge clock);
      guard++;
    end
    if (sb.size() != 0) fail_now("drain_scoreboard");
    repeat (3) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
